// File: rtl/uart_rx.sv
// 8N1-style serial receiver: 2-FF synchronizer, 16x oversampling FSM, LSB-first deframing.
// Optional UART_RX_MAJORITY_EN: data/stop bits decided by 2-of-3 vote over the last three ticks of each bit.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_done,
    output logic                 frame_err
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [3:0] S_MID  = 4'd7;
    localparam logic [3:0] S_LAST = 4'd15;
    localparam logic [3:0] S_STOP = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);

    state_t               state;
    logic [3:0]           s;
    logic [2:0]           n;
    logic [DATA_BITS-1:0] b;
    logic                 rx_q, rx_s;
    logic                 bit_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_q <= rx;
            rx_s <= rx_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] S_DWIN = 4'd13;
    localparam logic [3:0] S_SWIN = 4'(SB_TICK - 3);

    // Two earlier captures are held; the third vote is the live rx_s on the deciding tick.
    logic [1:0] smp;
    logic       win;

    assign win = b_tick && (((state == DATA) && (s >= S_DWIN)) ||
                            ((state == STOP) && (s >= S_SWIN)));
    assign bit_val = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);

    always_ff @(posedge clk) begin
        if (reset)
            smp <= 2'b00;
        else if (win)
            smp <= {smp[0], rx_s};
    end
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (b_tick) begin
                        if (s == S_MID) begin
                            // A start bit that is gone by mid-bit is a glitch.
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (b_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= {bit_val, b[DATA_BITS-1:1]};
                            if (n == N_LAST)
                                state <= STOP;
                            else
                                n <= n + 3'd1;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (b_tick) begin
                        if (s == S_STOP) begin
                            // Leave at mid-stop so an immediately following start bit is seen.
                            state <= IDLE;
                            if (bit_val) begin
                                d_out   <= b;
                                rx_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, back-to-back, glitch, framing error, mid-frame reset, bit-3 spike.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done, frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int tcnt = 0, tick_no = 0, done_tick = 0, start_tick = 0;
    logic [7:0] dlog[$];

    uart_rx #(.DATA_BITS(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .b_tick(b_tick), .rx(rx),
        .d_out(d_out), .rx_done(rx_done), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    // One b_tick per 163 clk (16 x 19200 Hz at 50 MHz).
    always @(posedge clk) begin
        tcnt   <= (tcnt == 162) ? 0 : tcnt + 1;
        b_tick <= (tcnt == 162);
        if (b_tick) tick_no <= tick_no + 1;
    end

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            done_tick = tick_no;
            dlog.push_back(d_out);
        end
        if (frame_err) err_cnt++;
        if (rx_done && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge following the n-th b_tick consumed by the DUT.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!b_tick);
        end
        @(negedge clk);
    endtask

    // glitch_bit >= 0 forces rx high for the single tick period covering s=15 of that bit.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int glitch_bit);
        rx = 1'b0;
        start_tick = tick_no;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == glitch_bit) begin
                wait_ticks(7);
                rx = 1'b1;
                wait_ticks(1);
                rx = data[i];
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_ticks(16);
        end else begin
            // Low long enough to cover the stop sample, then released so it is not a new start.
            rx = 1'b0;
            wait_ticks(10);
            rx = 1'b1;
            wait_ticks(6);
        end
    endtask

    initial begin
        int d0, e0;
        logic [7:0] abort_byte;
        repeat (4) @(negedge clk);
        chk("reset_d_out", d_out, 0);
        chk("reset_rx_done", rx_done, 0);
        chk("reset_frame_err", frame_err, 0);
        reset = 1'b0;
        wait_ticks(4);

        send_frame(8'hA5, 1'b1, -1);
        chk("a5_done_cnt", done_cnt, 1);
        chk("a5_d_out", d_out, 8'hA5);
        chk("a5_err_cnt", err_cnt, 0);
        chk("a5_latency_ticks", done_tick - start_tick, 152);
        wait_ticks(20);

        dlog.delete();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        chk("b2b_done_cnt", done_cnt, 3);
        chk("b2b_first", (dlog.size() > 0) ? int'(dlog[0]) : -1, 8'h00);
        chk("b2b_second", (dlog.size() > 1) ? int'(dlog[1]) : -1, 8'hFF);
        chk("b2b_err_cnt", err_cnt, 0);

        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(40);
        chk("glitch_done_cnt", done_cnt, 3);
        chk("glitch_err_cnt", err_cnt, 0);
        chk("glitch_d_out", d_out, 8'hFF);

        send_frame(8'h5A, 1'b0, -1);
        chk("ferr_err_cnt", err_cnt, 1);
        chk("ferr_done_cnt", done_cnt, 3);
        chk("ferr_d_out", d_out, 8'hFF);
        wait_ticks(20);
        send_frame(8'h3C, 1'b1, -1);
        chk("after_ferr_done_cnt", done_cnt, 4);
        chk("after_ferr_d_out", d_out, 8'h3C);
        wait_ticks(20);

        d0 = done_cnt;
        e0 = err_cnt;
        abort_byte = 8'h77;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            wait_ticks(16);
        end
        rx = abort_byte[4];
        wait_ticks(8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_d_out", d_out, 0);
        rx = 1'b1;
        wait_ticks(200);
        chk("rst_abort_done", done_cnt, d0);
        chk("rst_abort_err", err_cnt, e0);
        send_frame(8'h3C, 1'b1, -1);
        chk("rst_then_done_cnt", done_cnt, d0 + 1);
        chk("rst_then_d_out", d_out, 8'h3C);
        wait_ticks(20);

        send_frame(8'h00, 1'b1, 3);
`ifdef UART_RX_MAJORITY_EN
        chk("spike_bit3_d_out", d_out, 8'h00);
`else
        chk("spike_bit3_d_out", d_out, 8'h08);
`endif
        chk("spike_done_cnt", done_cnt, d0 + 2);
        chk("never_both", both_cnt, 0);
        chk("total_err_cnt", err_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
